// File: rtl/alu_seq_pkg.sv
// Shared ALU definitions: opcodes, SPR-side input/output op codes, flag bit indices.
// No timing: constants and types only.
// No flow control: the CPU and the ALU both import these encodings.
package alu_seq_pkg;

  // Datapath width that the flag and output-op layout assume
  localparam int ALU_W = 32;

  // Opcodes carried in i_data[3:0] on an OPC write
  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_XOR = 4'd4;
  localparam logic [3:0] OP_SHL = 4'd5;
  localparam logic [3:0] OP_SHR = 4'd6;
  localparam logic [3:0] OP_SRA = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;

  // Write targets selected by i_input_op
  localparam logic [1:0] INOP_A         = 2'd0;
  localparam logic [1:0] INOP_B         = 2'd1;
  localparam logic [1:0] INOP_OPC_START = 2'd2;
  localparam logic [1:0] INOP_B_START   = 2'd3;

  // Read selects on i_output_op
  localparam logic [1:0] OUTOP_RES_LO = 2'd0;
  localparam logic [1:0] OUTOP_RES_HI = 2'd1;
  localparam logic [1:0] OUTOP_A      = 2'd2;
  localparam logic [1:0] OUTOP_B      = 2'd3;

  // Bit positions inside o_result_flags
  localparam int FLAG_Z    = 0;
  localparam int FLAG_N    = 1;
  localparam int FLAG_C    = 2;
  localparam int FLAG_V    = 3;
  localparam int FLAG_DROP = 4;
  localparam int FLAG_W    = 5;

  // CPU SPR numbers 4..7 map one-to-one onto the input/output op codes
  localparam int SPR_ALU_BASE = 4;
  localparam int SPR_ALU_LAST = SPR_ALU_BASE + 3;

  // Sequencer states
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one partial product per cycle.
// Latency: done pulses the cycle after the MUL_CYCLES-th step (MUL_CYCLES+1 edges after start).
// No backpressure: start is only honoured when not busy; the caller owns the handshake.
module alu_mul_iter #(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_start,
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  output logic           o_busy,
  output logic           o_done,
  output logic [2*W-1:0] o_prod
);

  localparam logic [5:0] LAST_STEP = 6'(MUL_CYCLES - 1);

  logic [2*W-1:0] r_mcand;
  logic [W-1:0]   r_mplier;
  logic [2*W-1:0] r_acc;
  logic [5:0]     r_cnt;
  logic           r_busy;
  logic           r_done;

  // Capture operands at start, then add/shift once per cycle until the last step
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_busy) begin
        if (r_mplier[0]) begin
          r_acc <= r_acc + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 6'd1;
        if (r_cnt == LAST_STEP) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end else if (i_start) begin
        r_mcand  <= {{W{1'b0}}, i_a};
        r_mplier <= i_b;
        r_acc    <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_prod = r_acc;

endmodule

// File: rtl/alu_seq.sv
// SPR-attached ALU: latches A/B/OPC, runs single-cycle ops or a 32-step multiply, holds result+flags.
// Latency: 1 cycle for logic/arith ops, MUL_CYCLES+1 cycles for MUL.
// No stall: results are held until consumed; an unconsumed overwrite or a start while busy sets sticky DROP.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int W          = 32,
  parameter int MUL_CYCLES = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [1:0]   i_input_op,
  input  logic         i_data_valid,
  input  logic [W-1:0] i_data,
  input  logic [1:0]   i_output_op,
  input  logic         i_result_empty,
  output logic         o_result_valid,
  output logic [W-1:0] o_result,
  output logic [4:0]   o_result_flags
);

  alu_state_t r_state, w_state_nxt;

  logic [W-1:0]   r_a, r_b, r_res_lo, r_res_hi;
  logic [3:0]     r_opc;
  logic           r_z, r_n, r_c, r_v, r_drop, r_valid;

  logic           w_start, w_mul_start, w_start_drop, w_complete;
  logic [3:0]     w_opc_eff;
  logic [W-1:0]   w_b_eff;
  logic [W:0]     w_add, w_sub;
  logic [W-1:0]   w_lo, w_hi;
  logic           w_c, w_v;
  logic           w_mul_busy, w_mul_done;
  logic [2*W-1:0] w_prod;
  logic           w_consume;

  // A start writes OPC or B at the same edge, so the op must see the incoming value
  assign w_start   = i_data_valid &&
                     (i_input_op == INOP_OPC_START || i_input_op == INOP_B_START);
  assign w_opc_eff = (i_data_valid && i_input_op == INOP_OPC_START) ? i_data[3:0] : r_opc;
  assign w_b_eff   = (i_data_valid && i_input_op == INOP_B_START)   ? i_data      : r_b;
  assign w_consume = i_result_empty && r_valid;

  // Operand/opcode registers accept writes in every state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_opc <= '0;
    end else if (i_data_valid) begin
      case (i_input_op)
        INOP_A:         r_a   <= i_data;
        INOP_B:         r_b   <= i_data;
        INOP_OPC_START: r_opc <= i_data[3:0];
        default:        r_b   <= i_data;
      endcase
    end
  end

  // Sequencer state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, multiplier launch, completion and dropped-start detection
  always_comb begin
    w_state_nxt  = r_state;
    w_mul_start  = 1'b0;
    w_start_drop = 1'b0;
    w_complete   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (w_opc_eff == OP_MUL) begin
            w_mul_start = 1'b1;
            w_state_nxt = ST_MUL;
          end else begin
            w_complete = 1'b1;
          end
        end
      end
      ST_MUL: begin
        w_start_drop = w_start;
        if (w_mul_done) begin
          w_complete  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  alu_mul_iter #(
    .W          (W),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_start (w_mul_start),
    .i_a     (r_a),
    .i_b     (w_b_eff),
    .o_busy  (w_mul_busy),
    .o_done  (w_mul_done),
    .o_prod  (w_prod)
  );

  assign w_add = {1'b0, r_a} + {1'b0, w_b_eff};
  assign w_sub = {1'b0, r_a} + {1'b0, ~w_b_eff} + {{W{1'b0}}, 1'b1};

  // Result word and C/V for whatever completes this cycle
  always_comb begin
    w_lo = '0;
    w_hi = '0;
    w_c  = 1'b0;
    w_v  = 1'b0;
    if (r_state == ST_MUL) begin
      w_lo = w_prod[W-1:0];
      w_hi = w_prod[2*W-1:W];
      w_c  = |w_prod[2*W-1:W];
    end else begin
      case (w_opc_eff)
        OP_ADD: begin
          w_lo = w_add[W-1:0];
          w_hi = {{(W-1){1'b0}}, w_add[W]};
          w_c  = w_add[W];
          w_v  = (r_a[W-1] == w_b_eff[W-1]) && (w_add[W-1] != r_a[W-1]);
        end
        OP_SUB: begin
          w_lo = w_sub[W-1:0];
          w_hi = {{(W-1){1'b0}}, ~w_sub[W]};
          w_c  = ~w_sub[W];
          w_v  = (r_a[W-1] != w_b_eff[W-1]) && (w_sub[W-1] != r_a[W-1]);
        end
        OP_AND:  w_lo = r_a & w_b_eff;
        OP_OR:   w_lo = r_a | w_b_eff;
        OP_XOR:  w_lo = r_a ^ w_b_eff;
        OP_SHL:  w_lo = r_a << w_b_eff[4:0];
        OP_SHR:  w_lo = r_a >> w_b_eff[4:0];
        OP_SRA:  w_lo = $signed(r_a) >>> w_b_eff[4:0];
        default: w_lo = '0;
      endcase
    end
  end

  // Held result and flags, rewritten on every completion
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_res_lo <= '0;
      r_res_hi <= '0;
      r_z      <= 1'b0;
      r_n      <= 1'b0;
      r_c      <= 1'b0;
      r_v      <= 1'b0;
    end else if (w_complete) begin
      r_res_lo <= w_lo;
      r_res_hi <= w_hi;
      r_z      <= (w_lo == '0);
      r_n      <= w_lo[W-1];
      r_c      <= w_c;
      r_v      <= w_v;
    end
  end

  // Valid/DROP: completion beats a same-cycle consume; DROP is sticky until consumed
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (w_consume) begin
        r_valid <= 1'b0;
      end
      r_drop <= w_start_drop ||
                (w_complete && r_valid && !i_result_empty) ||
                (r_drop && !w_consume);
    end
  end

  // Combinational read port over the held registers
  always_comb begin
    o_result = '0;
    case (i_output_op)
      OUTOP_RES_LO: o_result = r_res_lo;
      OUTOP_RES_HI: o_result = r_res_hi;
      OUTOP_A:      o_result = r_a;
      default:      o_result = r_b;
    endcase
  end

  assign o_result_valid = r_valid;
  assign o_result_flags = r_valid ? {r_drop, r_v, r_c, r_n, r_z} : 5'd0;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors through SPR-style writes/reads.
// Latency: checks 1-cycle ops and the 33-cycle multiply completion.
// Backpressure: exercises consume, overwrite-DROP, start-while-busy DROP and consume/complete collision.
module tb_alu_seq;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [1:0]  i_input_op = 2'd0;
  logic        i_data_valid = 1'b0;
  logic [31:0] i_data = 32'd0;
  logic [1:0]  i_output_op = 2'd0;
  logic        i_result_empty = 1'b0;
  logic        o_result_valid;
  logic [31:0] o_result;
  logic [4:0]  o_result_flags;

  int checks = 0;
  int failures = 0;

  always #5 i_clk = ~i_clk;

  alu_seq dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_input_op     (i_input_op),
    .i_data_valid   (i_data_valid),
    .i_data         (i_data),
    .i_output_op    (i_output_op),
    .i_result_empty (i_result_empty),
    .o_result_valid (o_result_valid),
    .o_result       (o_result),
    .o_result_flags (o_result_flags)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // One SPR write lasting one clock; optional consume in the same cycle
  task automatic wr(input logic [1:0] op, input logic [31:0] d, input logic empty = 1'b0);
    i_input_op     = op;
    i_data         = d;
    i_data_valid   = 1'b1;
    i_result_empty = empty;
    tick();
    i_data_valid   = 1'b0;
    i_result_empty = 1'b0;
  endtask

  task automatic consume();
    i_result_empty = 1'b1;
    tick();
    i_result_empty = 1'b0;
  endtask

  task automatic rd(input logic [1:0] op, output logic [31:0] v);
    i_output_op = op;
    #1;
    v = o_result;
  endtask

  // Wait for valid up to a bound; returns cycles waited (-1 on timeout)
  task automatic wait_valid(input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (o_result_valid) begin
        n = k;
        break;
      end
    end
  endtask

  logic [31:0] v;
  int n;

  initial begin
    // Reset state
    tick(); tick();
    i_rst = 1'b0;
    tick();
    chk("rst_valid", {31'd0, o_result_valid}, 32'd0);
    chk("rst_flags", {27'd0, o_result_flags}, 32'd0);
    for (int op = 0; op < 4; op++) begin
      rd(2'(op), v);
      chk($sformatf("rst_out%0d", op), v, 32'd0);
    end

    // Reset mid-multiply
    wr(2'd0, 32'd5);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd8);
    for (int k = 0; k < 9; k++) tick();
    i_rst = 1'b1;
    #2;
    chk("midrst_valid", {31'd0, o_result_valid}, 32'd0);
    chk("midrst_flags", {27'd0, o_result_flags}, 32'd0);
    for (int op = 0; op < 4; op++) begin
      rd(2'(op), v);
      chk($sformatf("midrst_out%0d", op), v, 32'd0);
    end
    tick();
    i_rst = 1'b0;
    tick();
    wr(2'd0, 32'd1);
    wr(2'd1, 32'd1);
    wr(2'd2, 32'd0);
    rd(2'd0, v);
    chk("post_rst_add", v, 32'd2);
    for (int k = 0; k < 40; k++) tick();
    rd(2'd0, v);
    chk("post_rst_stable", v, 32'd2);
    consume();

    // ADD overflow
    wr(2'd0, 32'h7FFFFFFF);
    wr(2'd1, 32'd1);
    chk("add_pre_valid", {31'd0, o_result_valid}, 32'd0);
    wr(2'd2, 32'd0);
    chk("add_valid", {31'd0, o_result_valid}, 32'd1);
    rd(2'd0, v);
    chk("add_lo", v, 32'h80000000);
    rd(2'd1, v);
    chk("add_hi", v, 32'd0);
    chk("add_flags", {27'd0, o_result_flags}, 32'h0A);
    consume();

    // SUB borrow via B+start with OPC preloaded
    wr(2'd0, 32'd3);
    wr(2'd2, 32'd1);
    consume();
    wr(2'd3, 32'd5);
    rd(2'd0, v);
    chk("sub_lo", v, 32'hFFFFFFFE);
    rd(2'd1, v);
    chk("sub_hi", v, 32'd1);
    chk("sub_flags", {27'd0, o_result_flags}, 32'h06);
    consume();
    chk("sub_consumed", {31'd0, o_result_valid}, 32'd0);
    chk("sub_consumed_flags", {27'd0, o_result_flags}, 32'd0);

    // MUL latency
    wr(2'd0, 32'hFFFFFFFF);
    wr(2'd1, 32'd2);
    wr(2'd2, 32'd8);
    wait_valid(40, n);
    chk("mul_latency", 32'(n), 32'd33);
    rd(2'd0, v);
    chk("mul_lo", v, 32'hFFFFFFFE);
    rd(2'd1, v);
    chk("mul_hi", v, 32'd1);
    chk("mul_flags", {27'd0, o_result_flags}, 32'h06);
    rd(2'd2, v);
    chk("mul_rd_a", v, 32'hFFFFFFFF);
    consume();

    // DROP on start while multiplying
    wr(2'd0, 32'd6);
    wr(2'd1, 32'd7);
    wr(2'd2, 32'd8);
    for (int k = 0; k < 4; k++) tick();
    wr(2'd2, 32'd2);
    chk("drop_not_yet_valid", {31'd0, o_result_valid}, 32'd0);
    wait_valid(40, n);
    chk("drop_mul_done", {31'd0, o_result_valid}, 32'd1);
    rd(2'd0, v);
    chk("drop_mul_lo", v, 32'd42);
    chk("drop_flags", {27'd0, o_result_flags}, 32'h10);
    consume();
    wr(2'd3, 32'd7);
    rd(2'd0, v);
    chk("opc_kept_and", v, 32'd6);
    chk("and_flags", {27'd0, o_result_flags}, 32'd0);

    // Simultaneous consume and completion
    consume();
    wr(2'd0, 32'd10);
    wr(2'd1, 32'd3);
    wr(2'd2, 32'd0);
    rd(2'd0, v);
    chk("held_add", v, 32'd13);
    wr(2'd2, 32'd4, 1'b1);
    chk("collide_valid", {31'd0, o_result_valid}, 32'd1);
    rd(2'd0, v);
    chk("collide_xor", v, 32'd9);
    chk("collide_flags", {27'd0, o_result_flags}, 32'd0);

    // Overwrite without consume sets DROP
    wr(2'd2, 32'd3);
    rd(2'd0, v);
    chk("overwrite_or", v, 32'd11);
    chk("overwrite_flags", {27'd0, o_result_flags}, 32'h10);
    consume();

    // Undefined opcode and arithmetic right shift
    wr(2'd2, 32'd9);
    rd(2'd0, v);
    chk("opc9_lo", v, 32'd0);
    chk("opc9_flags", {27'd0, o_result_flags}, 32'h01);
    consume();
    wr(2'd0, 32'h80000000);
    wr(2'd1, 32'd4);
    wr(2'd2, 32'd7);
    rd(2'd0, v);
    chk("sra_lo", v, 32'hF8000000);
    chk("sra_flags", {27'd0, o_result_flags}, 32'h02);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
